// File: rtl/sram_arb_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | sram_arb_pkg : shared types and default widths for the SRAM arbiter       |
// | Revision     : 1.0                                                        |
// +--------------------------------------------------------------------------+
package sram_arb_pkg;

  localparam int DEF_DATA_WIDTH = 8;
  localparam int DEF_ADDR_WIDTH = 9;
  localparam int DEF_MAX_WAIT   = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FILL = 2'd1,
    DONE = 2'd2
  } fill_state_t;

  typedef enum logic [1:0] {
    GNT_NONE = 2'd0,
    GNT_P0   = 2'd1,
    GNT_P1   = 2'd2,
    GNT_FILL = 2'd3
  } gnt_src_t;

endpackage
`default_nettype wire

// File: rtl/sram_arbiter_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | sram_arbiter_if : requester, fill-control and RAM-side signal bundle      |
// | Revision        : 1.0                                                     |
// +--------------------------------------------------------------------------+
interface sram_arbiter_if #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 9
);
  logic                  p0_req;
  logic [ADDR_WIDTH-1:0] p0_addr;
  logic                  p0_gnt;
  logic                  p0_rvalid;
  logic                  p1_req;
  logic                  p1_we;
  logic [ADDR_WIDTH-1:0] p1_addr;
  logic [DATA_WIDTH-1:0] p1_wdata;
  logic                  p1_gnt;
  logic                  p1_rvalid;
  logic [DATA_WIDTH-1:0] rdata;
  logic                  fill_start;
  logic [ADDR_WIDTH-1:0] fill_base;
  logic [ADDR_WIDTH:0]   fill_len;
  logic [DATA_WIDTH-1:0] fill_value;
  logic                  fill_busy;
  logic                  fill_done;
  logic                  mem_en;
  logic                  mem_we;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [DATA_WIDTH-1:0] mem_wdata;
  logic [DATA_WIDTH-1:0] mem_rdata;

  modport slave (
    input  p0_req, p0_addr, p1_req, p1_we, p1_addr, p1_wdata,
           fill_start, fill_base, fill_len, fill_value, mem_rdata,
    output p0_gnt, p0_rvalid, p1_gnt, p1_rvalid, rdata,
           fill_busy, fill_done, mem_en, mem_we, mem_addr, mem_wdata
  );

  modport master (
    output p0_req, p0_addr, p1_req, p1_we, p1_addr, p1_wdata,
           fill_start, fill_base, fill_len, fill_value, mem_rdata,
    input  p0_gnt, p0_rvalid, p1_gnt, p1_rvalid, rdata,
           fill_busy, fill_done, mem_en, mem_we, mem_addr, mem_wdata
  );
endinterface
`default_nettype wire

// File: rtl/sram_fill_seq.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | sram_fill_seq : fill FSM walking base..base+len-1, one word per grant     |
// | Revision      : 1.0                                                       |
// +--------------------------------------------------------------------------+
module sram_fill_seq
  import sram_arb_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] base,
  input  logic [ADDR_WIDTH:0]   len,
  input  logic [DATA_WIDTH-1:0] value,
  input  logic                  fill_gnt,
  output logic                  fill_req,
  output logic [ADDR_WIDTH-1:0] fill_addr,
  output logic [DATA_WIDTH-1:0] fill_data,
  output logic                  busy,
  output logic                  done
);

  localparam logic [ADDR_WIDTH:0] LEN_ONE = {{ADDR_WIDTH{1'b0}}, 1'b1};

  fill_state_t           state;
  fill_state_t           state_nxt;
  logic [ADDR_WIDTH-1:0] base_q;
  logic [ADDR_WIDTH:0]   len_q;
  logic [ADDR_WIDTH:0]   cnt_q;
  logic [DATA_WIDTH-1:0] value_q;
  logic                  accept;
  logic                  last;

  assign accept = (state == IDLE) && start && (len != '0);
  assign last   = (cnt_q == len_q - LEN_ONE);

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      base_q  <= '0;
      len_q   <= '0;
      cnt_q   <= '0;
      value_q <= '0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        base_q  <= base;
        len_q   <= len;
        value_q <= value;
        cnt_q   <= '0;
      end else if ((state == FILL) && fill_gnt) begin
        cnt_q <= cnt_q + LEN_ONE;
      end
    end
  end

  // A zero-length start goes straight to DONE so it still reports completion.
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (start) state_nxt = (len != '0) ? FILL : DONE;
      FILL:    if (fill_gnt && last) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign fill_req  = (state == FILL);
  assign busy      = (state == FILL);
  assign done      = (state == DONE);
  assign fill_addr = base_q + cnt_q[ADDR_WIDTH-1:0];
  assign fill_data = value_q;

endmodule
`default_nettype wire

// File: rtl/sram_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | sram_arbiter : P0 > fill > P1 arbiter for a single-port 1-cycle RAM       |
// | Optional starvation guard: define SRAM_ARB_STARVE_GUARD_EN. Revision 1.0  |
// +--------------------------------------------------------------------------+
module sram_arbiter
  import sram_arb_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int MAX_WAIT   = DEF_MAX_WAIT
) (
  input  logic          clk,
  input  logic          reset,
  sram_arbiter_if.slave bus
);

  gnt_src_t              src;
  logic                  fill_req;
  logic                  fill_gnt;
  logic                  fill_busy;
  logic                  fill_done;
  logic [ADDR_WIDTH-1:0] fill_addr;
  logic [DATA_WIDTH-1:0] fill_data;
  logic                  p1_ok;
  logic                  boost;
  logic                  p0_rvalid_q;
  logic                  p1_rvalid_q;

  if (MAX_WAIT < 1) begin : g_max_wait_check
    $error("sram_arbiter: MAX_WAIT must be at least 1");
  end

  sram_fill_seq #(
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_fill_seq (
    .clk       (clk),
    .reset     (reset),
    .start     (bus.fill_start),
    .base      (bus.fill_base),
    .len       (bus.fill_len),
    .value     (bus.fill_value),
    .fill_gnt  (fill_gnt),
    .fill_req  (fill_req),
    .fill_addr (fill_addr),
    .fill_data (fill_data),
    .busy      (fill_busy),
    .done      (fill_done)
  );

  assign p1_ok    = bus.p1_req && !fill_busy;
  assign fill_gnt = (src == GNT_FILL);

`ifdef SRAM_ARB_STARVE_GUARD_EN
  localparam int WAIT_W = $clog2(MAX_WAIT + 1);

  logic [WAIT_W-1:0] wait_cnt;
  logic              chal_pend;
  logic              chal_gnt;

  // The challenger is whichever non-P0 source currently has priority.
  assign chal_pend = fill_busy ? fill_req : bus.p1_req;
  assign chal_gnt  = fill_busy ? (src == GNT_FILL) : (src == GNT_P1);
  assign boost     = (wait_cnt == WAIT_W'(MAX_WAIT));

  always_ff @(posedge clk) begin
    if (reset) begin
      wait_cnt <= '0;
    end else if (chal_pend && !chal_gnt) begin
      wait_cnt <= wait_cnt + WAIT_W'(1);
    end else begin
      wait_cnt <= '0;
    end
  end
`else
  assign boost = 1'b0;
`endif

  always_comb begin
    src = GNT_NONE;
    if (!reset) begin
      if (boost && fill_req)      src = GNT_FILL;
      else if (boost && p1_ok)    src = GNT_P1;
      else if (bus.p0_req)        src = GNT_P0;
      else if (fill_req)          src = GNT_FILL;
      else if (p1_ok)             src = GNT_P1;
    end
  end

  always_comb begin
    bus.mem_addr  = '0;
    bus.mem_wdata = '0;
    unique case (src)
      GNT_P0:   bus.mem_addr = bus.p0_addr;
      GNT_P1: begin
        bus.mem_addr = bus.p1_addr;
        if (bus.p1_we) bus.mem_wdata = bus.p1_wdata;
      end
      GNT_FILL: begin
        bus.mem_addr  = fill_addr;
        bus.mem_wdata = fill_data;
      end
      default: ;
    endcase
  end

  assign bus.p0_gnt = (src == GNT_P0);
  assign bus.p1_gnt = (src == GNT_P1);
  assign bus.mem_en = (src != GNT_NONE);
  assign bus.mem_we = (src == GNT_FILL) || ((src == GNT_P1) && bus.p1_we);

  always_ff @(posedge clk) begin
    if (reset) begin
      p0_rvalid_q <= 1'b0;
      p1_rvalid_q <= 1'b0;
    end else begin
      p0_rvalid_q <= (src == GNT_P0);
      p1_rvalid_q <= (src == GNT_P1) && !bus.p1_we;
    end
  end

  assign bus.p0_rvalid = p0_rvalid_q;
  assign bus.p1_rvalid = p1_rvalid_q;
  assign bus.rdata     = (p0_rvalid_q || p1_rvalid_q) ? bus.mem_rdata : '0;
  assign bus.fill_busy = fill_busy;
  assign bus.fill_done = fill_done;

endmodule
`default_nettype wire

// File: tb/tb_sram_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_sram_arbiter : vector table, directed corner cases, random vs model    |
// | Revision        : 1.0                                                     |
// +--------------------------------------------------------------------------+
module tb_sram_arbiter;

  localparam int DW       = 8;
  localparam int AW       = 9;
  localparam int MAX_WAIT = 4;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  sram_arbiter_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

  sram_arbiter #(
    .DATA_WIDTH (DW),
    .ADDR_WIDTH (AW),
    .MAX_WAIT   (MAX_WAIT)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // Write-first single-port RAM with a backdoor for preloading.
  logic [DW-1:0] ram [2**AW];
  logic [DW-1:0] ram_q   = '0;
  logic          bd_we   = 1'b0;
  logic [AW-1:0] bd_addr = '0;
  logic [DW-1:0] bd_data = '0;
  assign bus.mem_rdata = ram_q;

  always @(posedge clk) begin
    if (bd_we) begin
      ram[bd_addr] <= bd_data;
    end else if (bus.mem_en) begin
      if (bus.mem_we) begin
        ram[bus.mem_addr] <= bus.mem_wdata;
        ram_q             <= bus.mem_wdata;
      end else begin
        ram_q <= ram[bus.mem_addr];
      end
    end
  end

  // Requests must be held until granted.
  logic p0_hold = 1'b0;
  logic p1_hold = 1'b0;
  always @(posedge clk) begin
    if (reset) begin
      p0_hold <= 1'b0;
      p1_hold <= 1'b0;
    end else begin
      assert (!(p0_hold && !bus.p0_req)) else $error("protocol: p0_req dropped before grant");
      assert (!(p1_hold && !bus.p1_req)) else $error("protocol: p1_req dropped before grant");
      p0_hold <= bus.p0_req && !bus.p0_gnt;
      p1_hold <= bus.p1_req && !bus.p1_gnt;
    end
  end

  int tests = 0;
  int fails = 0;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", nm, got, exp, $time);
    end
  endtask

  `define CHK(n, g, e) chk(n, 32'(g), 32'(e))

  typedef struct {
    logic          p0_req;
    logic [AW-1:0] p0_addr;
    logic          p1_req;
    logic          p1_we;
    logic [AW-1:0] p1_addr;
    logic [DW-1:0] p1_wdata;
    logic          e_p0g;
    logic          e_p1g;
    logic          e_we;
    logic [AW-1:0] e_addr;
    logic          e_p0v;
    logic          e_p1v;
    logic [DW-1:0] e_rdata;
  } vec_t;

  vec_t vt [6];

  task automatic idle_inputs();
    bus.p0_req     = 1'b0;
    bus.p0_addr    = '0;
    bus.p1_req     = 1'b0;
    bus.p1_we      = 1'b0;
    bus.p1_addr    = '0;
    bus.p1_wdata   = '0;
    bus.fill_start = 1'b0;
    bus.fill_base  = '0;
    bus.fill_len   = '0;
    bus.fill_value = '0;
  endtask

  task automatic poke(input logic [AW-1:0] a, input logic [DW-1:0] d);
    @(negedge clk);
    bd_we   = 1'b1;
    bd_addr = a;
    bd_data = d;
    @(posedge clk);
    #1 bd_we = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic start_fill(input logic [AW-1:0] b, input logic [AW:0] l, input logic [DW-1:0] v);
    bus.fill_start = 1'b1;
    bus.fill_base  = b;
    bus.fill_len   = l;
    bus.fill_value = v;
  endtask

  // Reference model state: fill described as next address / words left.
  logic          m_busy, m_done, m_p0v, m_p1v;
  logic [AW-1:0] m_next;
  int            m_left, m_wait;
  logic [DW-1:0] m_val, m_rd;
  logic [DW-1:0] shadow [2**AW];

  task automatic model_step();
    int            src;
    logic          boost, p1_ok, idle_now, done_n, chal, chal_g, exp_we;
    logic [AW-1:0] ea;
    logic [DW-1:0] ew;
    boost = 1'b0;
`ifdef SRAM_ARB_STARVE_GUARD_EN
    boost = (m_wait == MAX_WAIT);
`endif
    p1_ok = bus.p1_req && !m_busy;
    if (boost && m_busy)      src = 3;
    else if (boost && p1_ok)  src = 2;
    else if (bus.p0_req)      src = 1;
    else if (m_busy)          src = 3;
    else if (p1_ok)           src = 2;
    else                      src = 0;
    exp_we = (src == 3) || ((src == 2) && bus.p1_we);
    ea = (src == 1) ? bus.p0_addr : (src == 2) ? bus.p1_addr : m_next;
    ew = (src == 3) ? m_val : bus.p1_wdata;

    `CHK("rnd p0_gnt", bus.p0_gnt, src == 1);
    `CHK("rnd p1_gnt", bus.p1_gnt, src == 2);
    `CHK("rnd mem_en", bus.mem_en, src != 0);
    `CHK("rnd mem_we", bus.mem_we, exp_we);
    if (src != 0) `CHK("rnd mem_addr", bus.mem_addr, ea);
    if (exp_we)   `CHK("rnd mem_wdata", bus.mem_wdata, ew);
    `CHK("rnd fill_busy", bus.fill_busy, m_busy);
    `CHK("rnd fill_done", bus.fill_done, m_done);
    `CHK("rnd p0_rvalid", bus.p0_rvalid, m_p0v);
    `CHK("rnd p1_rvalid", bus.p1_rvalid, m_p1v);
    if (m_p0v || m_p1v) `CHK("rnd rdata", bus.rdata, m_rd);

    m_p0v = (src == 1);
    m_p1v = (src == 2) && !bus.p1_we;
    m_rd  = shadow[ea];
    if (exp_we) shadow[ea] = ew;

    chal   = m_busy ? 1'b1 : bus.p1_req;
    chal_g = m_busy ? (src == 3) : (src == 2);
    m_wait = (chal && !chal_g) ? m_wait + 1 : 0;

    idle_now = !m_busy && !m_done;
    done_n   = 1'b0;
    if (src == 3) begin
      m_next = m_next + 9'd1;
      m_left--;
      if (m_left == 0) begin
        m_busy = 1'b0;
        done_n = 1'b1;
      end
    end else if (idle_now && bus.fill_start) begin
      if (bus.fill_len != '0) begin
        m_busy = 1'b1;
        m_next = bus.fill_base;
        m_left = int'(bus.fill_len);
        m_val  = bus.fill_value;
      end else begin
        done_n = 1'b1;
      end
    end
    m_done = done_n;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, got timeout, expected $finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic got_p0g, got_p1g;
    idle_inputs();

    //                p0   p0_addr  p1   we   p1_addr  wdata   p0g  p1g  we   e_addr   p0v  p1v  rdata
    vt[0] = '{1'b1, 9'h005, 1'b0, 1'b0, 9'h000, 8'h00, 1'b1, 1'b0, 1'b0, 9'h005, 1'b1, 1'b0, 8'h3C};
    vt[1] = '{1'b0, 9'h000, 1'b1, 1'b1, 9'h010, 8'hA5, 1'b0, 1'b1, 1'b1, 9'h010, 1'b0, 1'b0, 8'h00};
    vt[2] = '{1'b0, 9'h000, 1'b1, 1'b0, 9'h010, 8'h00, 1'b0, 1'b1, 1'b0, 9'h010, 1'b0, 1'b1, 8'hA5};
    vt[3] = '{1'b1, 9'h010, 1'b1, 1'b0, 9'h005, 8'h00, 1'b1, 1'b0, 1'b0, 9'h010, 1'b1, 1'b0, 8'hA5};
    vt[4] = '{1'b0, 9'h000, 1'b1, 1'b0, 9'h005, 8'h00, 1'b0, 1'b1, 1'b0, 9'h005, 1'b0, 1'b1, 8'h3C};
    vt[5] = '{1'b0, 9'h000, 1'b0, 1'b0, 9'h000, 8'h00, 1'b0, 1'b0, 1'b0, 9'h000, 1'b0, 1'b0, 8'h00};

    do_reset();
    poke(9'h005, 8'h3C);
    for (int a = 9'h1FD; a <= 9'h1FF; a++) poke(9'(a), 8'h5A);
    for (int a = 0; a <= 2; a++) poke(9'(a), 8'h5A);
    for (int a = 9'h080; a <= 9'h085; a++) poke(9'(a), 8'h11);

    do_reset();
    #1;
    `CHK("reset p0_gnt", bus.p0_gnt, 0);
    `CHK("reset p1_gnt", bus.p1_gnt, 0);
    `CHK("reset rvalid", {bus.p0_rvalid, bus.p1_rvalid}, 0);
    `CHK("reset rdata", bus.rdata, 0);
    `CHK("reset fill", {bus.fill_busy, bus.fill_done}, 0);
    `CHK("reset mem", {bus.mem_en, bus.mem_we, bus.mem_addr, bus.mem_wdata}, 0);

    // Single-cycle vectors with the rvalid/rdata result one edge later.
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      bus.p0_req   = vt[i].p0_req;
      bus.p0_addr  = vt[i].p0_addr;
      bus.p1_req   = vt[i].p1_req;
      bus.p1_we    = vt[i].p1_we;
      bus.p1_addr  = vt[i].p1_addr;
      bus.p1_wdata = vt[i].p1_wdata;
      #1;
      `CHK($sformatf("vec%0d p0_gnt", i), bus.p0_gnt, vt[i].e_p0g);
      `CHK($sformatf("vec%0d p1_gnt", i), bus.p1_gnt, vt[i].e_p1g);
      `CHK($sformatf("vec%0d mem_en", i), bus.mem_en, vt[i].e_p0g | vt[i].e_p1g);
      `CHK($sformatf("vec%0d mem_we", i), bus.mem_we, vt[i].e_we);
      if (vt[i].e_p0g | vt[i].e_p1g) `CHK($sformatf("vec%0d mem_addr", i), bus.mem_addr, vt[i].e_addr);
      @(posedge clk);
      #1;
      `CHK($sformatf("vec%0d p0_rvalid", i), bus.p0_rvalid, vt[i].e_p0v);
      `CHK($sformatf("vec%0d p1_rvalid", i), bus.p1_rvalid, vt[i].e_p1v);
      if (vt[i].e_p0v | vt[i].e_p1v) `CHK($sformatf("vec%0d rdata", i), bus.rdata, vt[i].e_rdata);
    end
    idle_inputs();
    @(negedge clk);

    // P0 holding the RAM against a pending P1.
    @(negedge clk);
    bus.p0_req = 1'b1; bus.p0_addr = 9'h001;
    bus.p1_req = 1'b1; bus.p1_we = 1'b0; bus.p1_addr = 9'h002;
`ifdef SRAM_ARB_STARVE_GUARD_EN
    for (int c = 1; c <= 5; c++) begin
      if (c > 1) @(negedge clk);
      #1;
      `CHK($sformatf("guard c%0d p1_gnt", c), bus.p1_gnt, c == 5);
      `CHK($sformatf("guard c%0d p0_gnt", c), bus.p0_gnt, c != 5);
    end
    @(negedge clk);
    bus.p1_req = 1'b0;
    #1 `CHK("guard p0 after boost", bus.p0_gnt, 1);
`else
    for (int c = 1; c <= 8; c++) begin
      if (c > 1) @(negedge clk);
      #1;
      `CHK($sformatf("strict c%0d p1_gnt", c), bus.p1_gnt, 0);
      `CHK($sformatf("strict c%0d p0_gnt", c), bus.p0_gnt, 1);
    end
    @(negedge clk);
    bus.p0_req = 1'b0;
    #1 `CHK("strict p1 after p0 drops", bus.p1_gnt, 1);
`endif
    @(negedge clk);
    idle_inputs();

    // Wrapping fill with P1 waiting throughout.
    @(negedge clk);
    start_fill(9'h1FE, 10'd4, 8'h00);
    #1 `CHK("fill start mem_en", bus.mem_en, 0);
    @(negedge clk);
    bus.fill_start = 1'b0;
    bus.p1_req = 1'b1; bus.p1_we = 1'b0; bus.p1_addr = 9'h1FF;
    for (int k = 0; k < 4; k++) begin
      if (k > 0) @(negedge clk);
      #1;
      `CHK($sformatf("fill w%0d mem_we", k), bus.mem_we, 1);
      `CHK($sformatf("fill w%0d addr", k), bus.mem_addr, 9'(9'h1FE + k));
      `CHK($sformatf("fill w%0d wdata", k), bus.mem_wdata, 8'h00);
      `CHK($sformatf("fill w%0d p1_gnt", k), bus.p1_gnt, 0);
      `CHK($sformatf("fill w%0d busy", k), bus.fill_busy, 1);
    end
    @(negedge clk);
    #1;
    `CHK("fill done pulse", bus.fill_done, 1);
    `CHK("fill done busy", bus.fill_busy, 0);
    `CHK("fill done p1_gnt", bus.p1_gnt, 1);
    `CHK("fill done p1 addr", bus.mem_addr, 9'h1FF);
    @(negedge clk);
    bus.p1_req = 1'b0;
    #1;
    `CHK("fill after done", bus.fill_done, 0);
    `CHK("fill p1_rvalid", bus.p1_rvalid, 1);
    `CHK("fill p1 rdata", bus.rdata, 8'h00);
    `CHK("fill ram 1FD", ram[9'h1FD], 8'h5A);
    `CHK("fill ram 1FE", ram[9'h1FE], 8'h00);
    `CHK("fill ram 000", ram[9'h000], 8'h00);
    `CHK("fill ram 001", ram[9'h001], 8'h00);
    `CHK("fill ram 002", ram[9'h002], 8'h5A);

    // Reset in the middle of a fill.
    @(negedge clk);
    start_fill(9'h080, 10'd6, 8'h77);
    @(negedge clk);
    bus.fill_start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    #1 `CHK("abort mem_en", bus.mem_en, 0);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      if (k == 1) reset = 1'b0;
      #1;
      `CHK($sformatf("abort c%0d busy", k), bus.fill_busy, 0);
      `CHK($sformatf("abort c%0d done", k), bus.fill_done, 0);
      `CHK($sformatf("abort c%0d mem_en", k), bus.mem_en, 0);
    end
    `CHK("abort ram 081", ram[9'h081], 8'h77);
    `CHK("abort ram 082", ram[9'h082], 8'h11);
    `CHK("abort ram 085", ram[9'h085], 8'h11);
    @(negedge clk);
    start_fill(9'h082, 10'd1, 8'h55);
    @(negedge clk);
    bus.fill_start = 1'b0;
    #1;
    `CHK("refill we", bus.mem_we, 1);
    `CHK("refill addr", bus.mem_addr, 9'h082);
    @(negedge clk);
    #1 `CHK("refill done", bus.fill_done, 1);
    `CHK("refill ram 082", ram[9'h082], 8'h55);
    `CHK("refill ram 083", ram[9'h083], 8'h11);

    // Zero-length fill.
    @(negedge clk);
    start_fill(9'h040, 10'd0, 8'hFF);
    #1 `CHK("len0 mem_en c0", bus.mem_en, 0);
    @(negedge clk);
    bus.fill_start = 1'b0;
    #1;
    `CHK("len0 done", bus.fill_done, 1);
    `CHK("len0 busy", bus.fill_busy, 0);
    `CHK("len0 mem_en c1", bus.mem_en, 0);
    @(negedge clk);
    #1 `CHK("len0 done cleared", bus.fill_done, 0);

    // A second start while filling is ignored.
    @(negedge clk);
    start_fill(9'h100, 10'd3, 8'hEE);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      if (k == 0) start_fill(9'h000, 10'd5, 8'h99);
      else bus.fill_start = 1'b0;
      #1;
      `CHK($sformatf("ign w%0d addr", k), bus.mem_addr, 9'(9'h100 + k));
      `CHK($sformatf("ign w%0d wdata", k), bus.mem_wdata, 8'hEE);
    end
    @(negedge clk);
    #1 `CHK("ign done", bus.fill_done, 1);
    @(negedge clk);
    #1;
    `CHK("ign no relaunch busy", bus.fill_busy, 0);
    `CHK("ign no relaunch mem_en", bus.mem_en, 0);

    // Randomized traffic against the reference model.
    idle_inputs();
    do_reset();
    m_busy = 1'b0; m_done = 1'b0; m_p0v = 1'b0; m_p1v = 1'b0;
    m_next = '0; m_left = 0; m_wait = 0; m_val = '0; m_rd = '0;
    for (int a = 0; a < 2**AW; a++) shadow[a] = ram[a];
    got_p0g = 1'b0;
    got_p1g = 1'b0;
    for (int cyc = 0; cyc < 1500; cyc++) begin
      if (cyc > 0) @(negedge clk);
      if (!bus.p0_req || got_p0g) begin
        bus.p0_req  = ($urandom_range(0, 2) == 0);
        bus.p0_addr = 9'($urandom_range(0, 15));
      end
      if (!bus.p1_req || got_p1g) begin
        bus.p1_req   = ($urandom_range(0, 1) == 0);
        bus.p1_we    = 1'($urandom_range(0, 1));
        bus.p1_addr  = 9'($urandom_range(0, 15));
        bus.p1_wdata = 8'($urandom);
      end
      bus.fill_start = ($urandom_range(0, 24) == 0);
      bus.fill_base  = ($urandom_range(0, 7) == 0) ? 9'h1FD : 9'($urandom_range(0, 15));
      bus.fill_len   = 10'($urandom_range(0, 6));
      bus.fill_value = 8'($urandom);
      #1;
      model_step();
      got_p0g = bus.p0_gnt;
      got_p1g = bus.p1_gnt;
    end
    @(negedge clk);
    idle_inputs();
    repeat (2) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  `undef CHK

endmodule
`default_nettype wire
